load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sequential load/store stage directly downstream of the ALU.
- Takes the ALU result as the effective byte address, together with the rs2 store data and funct3 of the current load/store instruction.
- Drives a word-wide data-memory request/acknowledge interface, applies byte lanes, and returns a sign- or zero-extended load result for write-back.
- Asserts busy so the single-cycle core stalls its PC while an access is outstanding.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT, 255, max cycles to wait for mem_ack before aborting (1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load/store request present.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
- ADDR  input  WIDTH  effective byte address (ALU OUT).
- WDATA  input  WIDTH  store data (rs2).
- busy  output  1  access in progress; core must hold its inputs stable.
- resp_valid  output  1  one-cycle pulse: access complete.
- RDATA  output  WIDTH  extended load data, valid with resp_valid.
- err  output  2  with resp_valid: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  WIDTH  word address = {ADDR[WIDTH-1:2], 2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  WIDTH  lane-replicated store data.
- mem_ack  input  1  memory completes the access this cycle.
- mem_rdata  input  WIDTH  read word, valid with mem_ack.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs are 0: busy, resp_valid, RDATA, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata. Timeout counter is 0.
- Reset asserted mid-access aborts immediately; no resp_valid is produced.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - When req_valid=1, request fields are captured into registers; inputs are not used after this edge.
  - Misaligned request (halfword with ADDR[0]=1, or word with ADDR[1:0]!=00) or illegal funct3 (any undefined load code; store with funct3 bit2=1) goes straight to RESP with the matching err. No memory access is made.
  - Otherwise go to ACCESS.
  - busy is combinationally 1 whenever req_valid=1 in IDLE, so the core stalls from the first cycle.
- ACCESS:
  - mem_req=1 with registered mem_addr/mem_we/mem_be/mem_wdata, held stable until mem_ack.
  - Counter increments each cycle without ack.
  - mem_ack=1 goes to RESP with err=00 and captures extracted data.
  - Counter reaching TIMEOUT without ack goes to RESP with err=10 and RDATA=0.
  - mem_ack in the same cycle as counter==TIMEOUT: ack wins.
- RESP: resp_valid=1 and busy=0 for exactly one cycle, then IDLE. A new req_valid is not accepted in RESP. Minimum latency is therefore request at cycle N, ACCESS at N+1, response at N+2 with a zero-wait ack.
- Byte enables: SB gives 0001 << ADDR[1:0]; SH gives 0011 << ADDR[1:0]; SW gives 1111. Loads drive mem_be=1111.
- Store data: SB replicates WDATA[7:0] to all 4 lanes; SH replicates WDATA[15:0] to both halves; SW passes WDATA through.
- Load extraction:
  - Byte = mem_rdata[8*ADDR[1:0] +: 8]; halfword = mem_rdata[16*ADDR[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores return RDATA=0.
- RDATA and err hold their value until the next response. resp_valid is registered.

Test Plan:
- LW at ADDR=0x0000_0100, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, resp_valid one cycle later, RDATA=0xDEADBEEF, err=00.
- LB at ADDR=0x103, rdata=0x80123456 -> RDATA=0xFFFFFF80; LBU same -> 0x00000080; LH at 0x102 -> 0xFFFF8012.
- SB at ADDR=0x101, WDATA=0x000000A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5, RDATA=0; SH at 0x102 WDATA=0x1234 -> be=1100, wdata=0x12341234.
- LW at ADDR=0x102 -> no mem_req at any cycle, resp_valid at N+1, err=01; LH funct3=011 -> err=11.
- LW with mem_ack never asserted, TIMEOUT=4 -> mem_req held 4 cycles then dropped, err=10, RDATA=0; ack arriving on the 4th cycle instead -> err=00.
- reset_n pulsed low during ACCESS -> all outputs 0 immediately, no resp_valid; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store stage: turns one ALU-addressed load or store into a single word-wide
// memory transaction and returns an extended load result and an error code.
module load_store_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] ADDR,
    input  logic [WIDTH-1:0] WDATA,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] RDATA,
    output logic [1:0]       err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is taken on any rising edge where req_valid=1 in IDLE;
    // the memory side completes on any edge where mem_req=1 and mem_ack=1.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             req_illegal, req_misal;
    logic [1:0]       req_err;
    logic [3:0]       st_be;
    logic [WIDTH-1:0] st_wdata;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_val;
    logic [7:0]       cnt_inc;
    logic             timeout_hit;

    // Request decode works on the live inputs; only used on the capture edge.
    always_comb begin
        if (req_we) begin
            req_illegal = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
        end
        req_misal = ((funct3[1:0] == 2'b01) & ADDR[0]) |
                    ((funct3[1:0] == 2'b10) & (ADDR[1:0] != 2'b00));
        if (req_illegal) begin
            req_err = 2'b11;
        end else if (req_misal) begin
            req_err = 2'b01;
        end else begin
            req_err = 2'b00;
        end
        st_be    = 4'b1111;
        st_wdata = WDATA;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ADDR[1:0];
                st_wdata = {4{WDATA[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ADDR[1:0];
                st_wdata = {2{WDATA[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TO_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (req_err != 2'b00) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ack takes priority over the timeout when both land on the same cycle.
    always_comb begin
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = funct3;
                    off_d   = ADDR[1:0];
                    addr_d  = {ADDR[WIDTH-1:2], 2'b00};
                    be_d    = req_we ? st_be : 4'b1111;
                    wdata_d = req_we ? st_wdata : '0;
                    cnt_d   = 8'd0;
                    if (req_err != 2'b00) begin
                        err_d   = req_err;
                        rdata_d = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    err_d   = 2'b00;
                    rdata_d = we_q ? '0 : ld_val;
                end else if (timeout_hit) begin
                    err_d   = 2'b10;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            err_q   <= 2'd0;
            rdata_q <= '0;
            cnt_q   <= 8'd0;
        end else begin
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        busy       = ((state_q == S_IDLE) && req_valid) || (state_q == S_ACCESS);
        resp_valid = (state_q == S_RESP);
        mem_req    = (state_q == S_ACCESS);
        mem_we     = mem_req && we_q;
        mem_addr   = mem_req ? addr_q  : '0;
        mem_be     = mem_req ? be_q    : 4'd0;
        mem_wdata  = mem_req ? wdata_q : '0;
        RDATA      = rdata_q;
        err        = err_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each step drives one request, queues the
// expected {err, RDATA}, plays a memory with a chosen ack delay and checks the response.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic        busy;
    logic        resp_valid;
    logic [31:0] RDATA;
    logic [1:0]  err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    logic [33:0] exp_q[$];
    int          checks;
    int          failures;

    load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .busy       (busy),
        .resp_valid (resp_valid),
        .RDATA      (RDATA),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [105:0] all_outputs();
        return {busy, resp_valid, RDATA, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata};
    endfunction

    // ack_after = 0 means memory never acknowledges.
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rd, input int ack_after,
                             input logic mem_exp, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [1:0] exp_err,
                             input logic [31:0] exp_rdata);
        int          cycles;
        int          reqs;
        int          exp_reqs;
        logic        got;
        logic [33:0] exp_item;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        ADDR      = addr;
        WDATA     = wdata;
        #1;
        check({tag, "_busy_req"}, busy, 1'b1);
        exp_q.push_back({exp_err, exp_rdata});
        exp_reqs = mem_exp ? ((ack_after == 0) ? 4 : ack_after) : 0;
        @(negedge clk);
        req_valid = 1'b0;
        ADDR      = $urandom;
        WDATA     = $urandom;
        funct3    = 3'($urandom_range(0, 7));
        cycles    = 0;
        reqs      = 0;
        got       = 1'b0;
        while (!got && cycles < 50) begin
            if (resp_valid) begin
                got      = 1'b1;
                exp_item = exp_q.pop_front();
                check({tag, "_resp"}, {err, RDATA}, exp_item);
                check({tag, "_resp_idle"}, {busy, mem_req}, 2'b00);
            end else begin
                if (mem_req) begin
                    reqs++;
                    check({tag, "_mem"}, {mem_addr, mem_be, mem_we},
                          {addr[31:2], 2'b00, exp_be, we});
                    if (we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
                    mem_ack   = (reqs == ack_after);
                    mem_rdata = mem_ack ? rd : $urandom;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
                cycles++;
            end
        end
        mem_ack = 1'b0;
        check({tag, "_got_resp"}, got, 1'b1);
        check({tag, "_mem_cycles"}, reqs, exp_reqs);
        check({tag, "_latency"}, cycles, exp_reqs);
        @(negedge clk);
        check({tag, "_pulse_hold"}, {resp_valid, err, RDATA}, {1'b0, exp_err, exp_rdata});
    endtask

    initial begin
        int seen;
        logic [31:0] sw_data;
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'd0;
        ADDR      = '0;
        WDATA     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outputs(), 106'd0);
        check("reset_state", dbg_state, 2'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", all_outputs(), 106'd0);

        sw_data = $urandom;
        //         tag      we  f3      addr          wdata         rdata         ack mem   be       wdata_exp     err    rdata_exp
        do_access("lw",    0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 1, 4'b1111, 32'h0,        2'b00, 32'hDEADBEEF);
        do_access("lb",    0, 3'b000, 32'h0000_0103, 32'h0,        32'h80123456, 1, 1, 4'b1111, 32'h0,        2'b00, 32'hFFFFFF80);
        do_access("lbu",   0, 3'b100, 32'h0000_0103, 32'h0,        32'h80123456, 2, 1, 4'b1111, 32'h0,        2'b00, 32'h00000080);
        do_access("lh",    0, 3'b001, 32'h0000_0102, 32'h0,        32'h80123456, 1, 1, 4'b1111, 32'h0,        2'b00, 32'hFFFF8012);
        do_access("lhu",   0, 3'b101, 32'h0000_0102, 32'h0,        32'h80123456, 1, 1, 4'b1111, 32'h0,        2'b00, 32'h00008012);
        do_access("lh_lo", 0, 3'b001, 32'h0000_0100, 32'h0,        32'h80123456, 1, 1, 4'b1111, 32'h0,        2'b00, 32'h00003456);
        do_access("lb_b1", 0, 3'b000, 32'h0000_0101, 32'h0,        32'h80123456, 1, 1, 4'b1111, 32'h0,        2'b00, 32'h00000034);
        do_access("lw_mis",0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        2'b01, 32'h0);
        do_access("lh_mis",0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        2'b01, 32'h0);
        do_access("lh_ill",0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        2'b11, 32'h0);
        do_access("st_ill",1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        2'b11, 32'h0);
        do_access("lw_pre",0, 3'b010, 32'h0000_0104, 32'h0,        32'h13579BDF, 1, 1, 4'b1111, 32'h0,        2'b00, 32'h13579BDF);
        do_access("sb",    1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'hFFFFFFFF, 1, 1, 4'b0010, 32'hA5A5A5A5, 2'b00, 32'h0);
        do_access("sh",    1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'hFFFFFFFF, 2, 1, 4'b1100, 32'h12341234, 2'b00, 32'h0);
        do_access("sw",    1, 3'b010, 32'h0000_0104, sw_data,       32'hFFFFFFFF, 1, 1, 4'b1111, sw_data,       2'b00, 32'h0);
        do_access("sb_b3", 1, 3'b000, 32'h0000_0103, 32'h7777_77C3, 32'hFFFFFFFF, 1, 1, 4'b1000, 32'hC3C3C3C3, 2'b00, 32'h0);
        do_access("lw_b4", 0, 3'b010, 32'h0000_0110, 32'h0,        32'h2468ACE0, 1, 1, 4'b1111, 32'h0,        2'b00, 32'h2468ACE0);
        do_access("lw_to", 0, 3'b010, 32'h0000_0108, 32'h0,        32'h0,        0, 1, 4'b1111, 32'h0,        2'b10, 32'h0);
        do_access("lw_ack4",0,3'b010, 32'h0000_010C, 32'h0,        32'h55AA33CC, 4, 1, 4'b1111, 32'h0,        2'b00, 32'h55AA33CC);

        // Reset in the middle of an access: abort without a response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = 3'b010;
        ADDR      = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_in_access", mem_req, 1'b1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", all_outputs(), 106'd0);
        check("rst_mid_state", dbg_state, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid || mem_req) seen++;
        end
        check("rst_mid_no_resp", seen, 0);
        do_access("lw_after_rst", 0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFEF00D, 1, 1, 4'b1111, 32'h0, 2'b00, 32'hCAFEF00D);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
